// File: rtl/flash_pkg.sv
// Shared constants and types for the flash read path (stream reader and spi_flash).
package flash_pkg;

    localparam int FLASH_ADDR_W = 24;

    localparam logic [7:0] CMD_STATUS = 8'h05;
    localparam logic [7:0] CMD_READ   = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

endpackage

// File: rtl/flash_stream_reader_if.sv
// Wishbone master bus towards spi_flash plus the outgoing valid/ready byte stream.
interface flash_stream_reader_if
    import flash_pkg::*;
#(
    parameter int ADDR_W = FLASH_ADDR_W
);

    logic [ADDR_W-1:0] wb_adr_o;
    logic [7:0]        wb_dat_o;
    logic [7:0]        wb_dat_i;
    logic              wb_we_o;
    logic              wb_sel_o;
    logic              wb_stb_o;
    logic              wb_cyc_o;
    logic              wb_ack_i;
    logic [7:0]        m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i,
        output m_data_o, m_valid_o,
        input  m_ready_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i,
        input  m_data_o, m_valid_o,
        output m_ready_i
    );

endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO with flush; head entry is readable while not empty.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign count   = count_reg;
    assign dout    = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/flash_stream_reader.sv
// Turns "read N bytes at address A" into single-byte classic Wishbone reads and
// streams the fetched bytes out through a small FWFT buffer.
module flash_stream_reader
    import flash_pkg::*;
#(
    parameter int ADDR_W         = FLASH_ADDR_W,
    parameter int LEN_W          = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_adr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    flash_stream_reader_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] adr_reg, adr_next;
    logic [LEN_W-1:0]  remain_reg, remain_next;
    logic              req_reg, req_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic              err_reg, err_next;
    logic              zdone_reg, zdone_next;
    logic              drain_done;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [7:0]        fifo_dout;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.wb_dat_i),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign fifo_pop      = !fifo_empty && bus.m_ready_i;
    assign bus.m_valid_o = !fifo_empty;
    assign bus.m_data_o  = fifo_empty ? 8'h00 : fifo_dout;

    assign bus.wb_adr_o = adr_reg;
    assign bus.wb_stb_o = req_reg;
    assign bus.wb_cyc_o = req_reg;
    assign bus.wb_dat_o = 8'h00;
    assign bus.wb_we_o  = 1'b0;
    assign bus.wb_sel_o = 1'b1;

    assign busy_o = (state_reg != IDLE);
    assign done_o = zdone_reg || drain_done;
    assign err_o  = err_reg;

    always_comb begin
        state_next  = state_reg;
        adr_next    = adr_reg;
        remain_next = remain_reg;
        req_next    = req_reg;
        tmo_next    = tmo_reg;
        err_next    = 1'b0;
        zdone_next  = 1'b0;
        drain_done  = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                req_next = 1'b0;
                tmo_next = '0;
                if (start_i && !abort_i) begin
                    if (len_i == '0) begin
                        zdone_next = 1'b1;
                    end else begin
                        adr_next    = start_adr_i;
                        remain_next = len_i;
                        req_next    = 1'b1;
                        state_next  = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort_i) begin
                    state_next  = IDLE;
                    req_next    = 1'b0;
                    tmo_next    = '0;
                    remain_next = '0;
                    fifo_flush  = 1'b1;
                end else if (req_reg) begin
                    if (bus.wb_ack_i) begin
                        fifo_push   = !fifo_full;
                        adr_next    = adr_reg + ADDR_W'(1);
                        remain_next = remain_reg - LEN_W'(1);
                        req_next    = 1'b0;
                        tmo_next    = '0;
                        if (remain_reg == LEN_W'(1)) begin
                            state_next = DRAIN;
                        end
                    end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_next  = IDLE;
                        req_next    = 1'b0;
                        tmo_next    = '0;
                        remain_next = '0;
                        err_next    = 1'b1;
                        fifo_flush  = 1'b1;
                    end else begin
                        tmo_next = tmo_reg + TMO_W'(1);
                    end
                end else begin
                    // Re-arm only when a slot is free, so an acked byte always fits.
                    req_next = (fifo_count < CNT_W'(FIFO_DEPTH));
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_next = IDLE;
                    fifo_flush = 1'b1;
                end else if (fifo_empty) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            adr_reg    <= '0;
            remain_reg <= '0;
            req_reg    <= 1'b0;
            tmo_reg    <= '0;
            err_reg    <= 1'b0;
            zdone_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            adr_reg    <= adr_next;
            remain_reg <= remain_next;
            req_reg    <= req_next;
            tmo_reg    <= tmo_next;
            err_reg    <= err_next;
            zdone_reg  <= zdone_next;
        end
    end

endmodule
